// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM type, accumulator width helper and output round/saturate functions
// Used by fir_transposed_param and fir_tap_stage.
// The round/saturate helpers work on MAXW-bit signed values, so callers sign-extend
// their sums to MAXW bits and take the low OUT_W bits of the saturated result.
package fir_pkg;

    localparam int MAXW = 128;

    typedef enum logic {ST_IDLE, ST_LOAD} state_t;

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Arithmetic right shift with round half-up (adds 1<<(shift-1) first).
    function automatic logic signed [MAXW-1:0] fir_round(input logic signed [MAXW-1:0] y, input int shift);
        logic signed [MAXW-1:0] half;
        half = '0;
        if (shift > 0) half[shift-1] = 1'b1;
        return (y + half) >>> shift;
    endfunction

    // Clip to the signed out_w-bit range.
    function automatic logic signed [MAXW-1:0] fir_sat(input logic signed [MAXW-1:0] r, input int out_w);
        logic signed [MAXW-1:0] lo;
        logic signed [MAXW-1:0] hi;
        lo = '1;
        lo = lo <<< (out_w - 1);
        hi = ~lo;
        return (r > hi) ? hi : ((r < lo) ? lo : r);
    endfunction

endpackage

// File: rtl/fir_tap_stage.sv
// fir_tap_stage: one transposed-form tap, s <= s_in + c*x on enable, cleared on i_clr
// Ports: clk, rst_n (async active-low); i_en advances the partial sum; i_clr zeroes it;
// i_x sample; i_c coefficient; i_s incoming partial sum; o_s registered partial sum.
module fir_tap_stage
    import fir_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [COEF_W-1:0] i_c,
    input  logic signed [ACC_W-1:0]  i_s,
    output logic signed [ACC_W-1:0]  o_s
);

    logic signed [ACC_W-1:0] r_s;
    logic signed [ACC_W-1:0] w_p;

    assign w_p = ACC_W'(i_x) * ACC_W'(i_c);
    assign o_s = r_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s <= '0;
        else if (i_clr) r_s <= '0;
        else if (i_en) r_s <= i_s + w_p;
    end

endmodule

// File: rtl/fir_transposed_param.sv
// fir_transposed_param: transposed-form FIR with runtime coefficient load, rounding and saturation
// Ports: clk, rst_n (async active-low); in_valid/in_data sample input;
// coef_start/coef_wr/coef_data coefficient load; coef_busy load in progress;
// out_valid/out_data/out_sat registered result, one cycle after an accepted sample.
// Build option: FIR_SYMMETRIC_EN stores ceil(TAPS/2) coefficients, word i drives c[i] and c[TAPS-1-i].
module fir_transposed_param
    import fir_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int COEF_W = 16,
    parameter int TAPS   = 20,
    parameter int OUT_W  = 29,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_start,
    input  logic                     coef_wr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_busy,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat
);

    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
`ifdef FIR_SYMMETRIC_EN
    localparam int NLOAD = (TAPS + 1) / 2;
`else
    localparam int NLOAD = TAPS;
`endif
    localparam int IDX_W = (NLOAD > 1) ? $clog2(NLOAD) : 1;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic signed [COEF_W-1:0] r_c [NLOAD];
    logic                    r_valid;
    logic signed [OUT_W-1:0] r_data;
    logic                    r_sat;

    logic signed [COEF_W-1:0] w_c [TAPS];
    logic signed [ACC_W-1:0]  w_s [1:TAPS-1];
    logic signed [ACC_W-1:0]  w_y;
    logic signed [MAXW-1:0]   w_r;
    logic                     w_acc;
    logic                     w_last;

    assign coef_busy = (r_state == ST_LOAD);
    assign w_acc     = in_valid && !coef_busy;
    // Final word of a load; a simultaneous coef_start drops it instead.
    assign w_last    = coef_busy && coef_wr && !coef_start && (r_idx == IDX_W'(NLOAD - 1));
    assign w_y       = ACC_W'(in_data) * ACC_W'(w_c[0]) + w_s[1];
    assign w_r       = fir_round(MAXW'(w_y), SHIFT);

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sat   = r_sat;

    for (genvar k = 0; k < TAPS; k++) begin : g_coef
`ifdef FIR_SYMMETRIC_EN
        assign w_c[k] = r_c[(k < NLOAD) ? k : TAPS - 1 - k];
`else
        assign w_c[k] = r_c[k];
`endif
    end

    for (genvar k = 1; k < TAPS; k++) begin : g_tap
        logic signed [ACC_W-1:0] w_sin;
        if (k == TAPS - 1) begin : g_end
            assign w_sin = '0;
        end else begin : g_mid
            assign w_sin = w_s[k+1];
        end
        fir_tap_stage #(
            .DATA_W(DATA_W),
            .COEF_W(COEF_W),
            .ACC_W (ACC_W)
        ) u_tap (
            .clk  (clk),
            .rst_n(rst_n),
            .i_en (w_acc),
            .i_clr(w_last),
            .i_x  (in_data),
            .i_c  (w_c[k]),
            .i_s  (w_sin),
            .o_s  (w_s[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            for (int i = 0; i < NLOAD; i++) r_c[i] <= '0;
        end else if (coef_start) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
        end else if (coef_busy && coef_wr) begin
            r_c[r_idx] <= coef_data;
            r_idx      <= r_idx + IDX_W'(1);
            if (w_last) r_state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= w_acc;
            if (w_acc) begin
                r_data <= OUT_W'(fir_sat(w_r, OUT_W));
                r_sat  <= fir_sat(w_r, OUT_W) != w_r;
            end
        end
    end

endmodule

// File: tb/tb_fir_transposed_param.sv
// tb_fir_transposed_param: scoreboard bench, default build (OUT_W=29) and a OUT_W=16/SHIFT=2 build
module tb_fir_transposed_param;

    localparam int DATA_W = 12;
    localparam int COEF_W = 16;
    localparam int TAPS   = 20;
`ifdef FIR_SYMMETRIC_EN
    localparam int NLOAD = (TAPS + 1) / 2;
`else
    localparam int NLOAD = TAPS;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic coef_start = 1'b0;
    logic coef_wr = 1'b0;
    logic signed [DATA_W-1:0] in_data = '0;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic busy1, busy2, val1, val2, sat1, sat2;
    logic signed [28:0] d1;
    logic signed [15:0] d2;

    typedef struct {
        longint d1;
        bit     s1;
        longint d2;
        bit     s2;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   words[$];
    int   cm[TAPS];
    bit   m_busy = 1'b0;
    int   m_idx = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fir_transposed_param u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .coef_start(coef_start), .coef_wr(coef_wr), .coef_data(coef_data),
        .coef_busy(busy1), .out_valid(val1), .out_data(d1), .out_sat(sat1)
    );

    fir_transposed_param #(.OUT_W(16), .SHIFT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .coef_start(coef_start), .coef_wr(coef_wr), .coef_data(coef_data),
        .coef_busy(busy2), .out_valid(val2), .out_data(d2), .out_sat(sat2)
    );

    function automatic longint clip(input longint v, input int w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        return (v > hi) ? hi : ((v < -hi - 1) ? -hi - 1 : v);
    endfunction

    // Drive one cycle, update the reference model, push the expected output at the edge.
    task automatic tick(input bit v, input int x, input bit st, input bit wr, input int d);
        exp_t   e;
        bit     push;
        longint acc;
        longint rnd;
        in_valid = v;
        in_data = DATA_W'(x);
        coef_start = st;
        coef_wr = wr;
        coef_data = COEF_W'(d);
        push = v && !m_busy;
        if (push) begin
            hist.push_front(x);
            if (hist.size() > TAPS) void'(hist.pop_back());
            acc = 0;
            foreach (hist[k]) acc += longint'(cm[k]) * longint'(hist[k]);
            rnd = (acc + 2) >>> 2;
            e.d1 = clip(acc, 29);
            e.s1 = e.d1 != acc;
            e.d2 = clip(rnd, 16);
            e.s2 = e.d2 != rnd;
        end
        if (st) begin
            m_busy = 1'b1;
            m_idx = 0;
        end else if (m_busy && wr) begin
            cm[m_idx] = d;
`ifdef FIR_SYMMETRIC_EN
            cm[TAPS-1-m_idx] = d;
`endif
            if (m_idx == NLOAD - 1) begin
                m_busy = 1'b0;
                hist.delete();
            end
            m_idx++;
        end
        @(posedge clk);
        if (push) sb.push_back(e);
        #1;
    endtask

    task automatic model_reset();
        foreach (cm[k]) cm[k] = 0;
        hist.delete();
        sb.delete();
        m_busy = 1'b0;
        m_idx = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (val1 || val2 || sb.size() > 0) begin
            total++;
            if (val1 !== val2) begin
                bad++;
                $display("FAIL out_valid_pair got %b/%b", val1, val2);
            end
            if (!val1) begin
                bad++;
                $display("FAIL out_valid_missing got 0 exp 1");
                void'(sb.pop_front());
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL out_valid_extra got 1 exp 0");
            end else begin
                e = sb.pop_front();
                if (d1 !== 29'(e.d1) || sat1 !== e.s1 || d2 !== 16'(e.d2) || sat2 !== e.s2) begin
                    bad++;
                    $display("FAIL output got d1=%0d s1=%b d2=%0d s2=%b exp d1=%0d s1=%b d2=%0d s2=%b",
                             d1, sat1, d2, sat2, e.d1, e.s1, e.d2, e.s2);
                end
            end
        end
    end

    task automatic load_words(input int stall_every);
        tick(1, 7, 1, 0, 0);
        foreach (words[i]) begin
            if (stall_every > 0 && i % stall_every == 0) tick(1, 7, 0, 0, 0);
            tick(1, 7, 0, 1, words[i]);
            total++;
            if (busy1 !== m_busy || busy2 !== m_busy) begin
                bad++;
                $display("FAIL coef_busy got %b/%b exp %b", busy1, busy2, m_busy);
            end
        end
    endtask

    task automatic impulse(input int gap);
        tick(1, 1, 0, 0, 0);
        repeat (gap) tick(0, 0, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) begin
            tick(1, 0, 0, 0, 0);
            repeat (gap) tick(0, 0, 0, 0, 0);
        end
        repeat (2) tick(0, 0, 0, 0, 0);
    endtask

    task automatic check_cleared(input string tag);
        total++;
        if (val1 !== 1'b0 || val2 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0 ||
            d1 !== 29'sd0 || d2 !== 16'sd0 || sat1 !== 1'b0 || sat2 !== 1'b0) begin
            bad++;
            $display("FAIL %s got v=%b%b b=%b%b d1=%0d d2=%0d s=%b%b exp all 0",
                     tag, val1, val2, busy1, busy2, d1, d2, sat1, sat2);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset_state");
        rst_n = 1'b1;
        impulse(0);
    endtask

    task automatic test_impulse();
        words.delete();
        for (int i = 0; i < NLOAD; i++) words.push_back(i + 1);
        load_words(0);
        impulse(0);
    endtask

    task automatic test_gapped();
        impulse(3);
    endtask

    task automatic test_saturation();
        words.delete();
        for (int i = 0; i < NLOAD; i++) words.push_back(32767);
        load_words(0);
        repeat (TAPS + 2) tick(1, 2047, 0, 0, 0);
        total++;
        if (d1 !== 29'sd268435455 || sat1 !== 1'b1 || d2 !== 16'sd32767 || sat2 !== 1'b1) begin
            bad++;
            $display("FAIL sat_pos got d1=%0d s1=%b d2=%0d s2=%b", d1, sat1, d2, sat2);
        end
        repeat (TAPS + 2) tick(1, -2048, 0, 0, 0);
        total++;
        if (d1 !== -29'sd268435456 || sat1 !== 1'b1 || d2 !== -16'sd32768 || sat2 !== 1'b1) begin
            bad++;
            $display("FAIL sat_neg got d1=%0d s1=%b d2=%0d s2=%b", d1, sat1, d2, sat2);
        end
        repeat (2) tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_rounding();
        int xin[3] = '{5, -5, 6};
        int yr[3] = '{1, -1, 2};
        words.delete();
        words.push_back(1);
        for (int i = 1; i < NLOAD; i++) words.push_back(0);
        load_words(0);
        for (int i = 0; i < 3; i++) begin
            tick(1, xin[i], 0, 0, 0);
            total++;
            if (d2 !== 16'(yr[i]) || d1 !== 29'(xin[i]) || sat2 !== 1'b0) begin
                bad++;
                $display("FAIL round got d2=%0d d1=%0d exp d2=%0d d1=%0d", d2, d1, yr[i], xin[i]);
            end
        end
        repeat (2) tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_load_restart();
        tick(0, 0, 0, 1, 555);
        tick(1, 3, 1, 0, 0);
        for (int i = 0; i < 7; i++) tick(1, 3, 0, 1, 100 + i);
        words.delete();
        for (int i = 0; i < NLOAD; i++) words.push_back(3 * i - 10);
        tick(1, 3, 1, 1, 999);
        foreach (words[i]) begin
            if (i % 3 == 0) tick(1, 3, 0, 0, 0);
            tick(1, 3, 0, 1, words[i]);
            total++;
            if (busy1 !== m_busy || busy2 !== m_busy) begin
                bad++;
                $display("FAIL restart_busy got %b/%b exp %b", busy1, busy2, m_busy);
            end
        end
        impulse(0);
    endtask

    task automatic test_reset_mid();
        tick(1, 1, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check_cleared("reset_mid_stream");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        impulse(0);
        words.delete();
        for (int i = 0; i < NLOAD; i++) words.push_back(i + 1);
        tick(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 4, 0, 1, 50 + i);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        coef_wr = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check_cleared("reset_mid_load");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        impulse(0);
        load_words(0);
        impulse(0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_impulse();
        test_gapped();
        test_saturation();
        test_rounding();
        test_load_restart();
        test_reset_mid();
        repeat (3) tick(0, 0, 0, 0, 0);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
